// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data RAM: core (port 0) has priority,
// the debug/loader master (port 1) is guaranteed a grant after MAX_WAIT refused cycles.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DEPTH    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [3:0]               m0_be,
    input  logic [AW-1:0]            m0_addr,
    input  logic [31:0]              m0_wdata,
    output logic                     m0_gnt,
    output logic                     m0_rvalid,
    output logic [31:0]              m0_rdata,
    output logic                     m0_err,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [3:0]               m1_be,
    input  logic [AW-1:0]            m1_addr,
    input  logic [31:0]              m1_wdata,
    output logic                     m1_gnt,
    output logic                     m1_rvalid,
    output logic [31:0]              m1_rdata,
    output logic                     m1_err,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [3:0]               ram_be,
    output logic [$clog2(DEPTH)-1:0] ram_addr,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata
);

    localparam int              IW       = $clog2(DEPTH);
    localparam logic [AW-3:0]   LP_DEPTH = (AW-2)'(DEPTH);
    localparam logic [3:0]      LP_MAX   = 4'(MAX_WAIT);

    logic [3:0]    r_wait_cnt;
    logic          r_resp_valid;
    logic          r_resp_sel;
    logic          r_resp_we;
    logic          r_resp_err;

    logic          w_sel0;
    logic          w_sel1;
    logic          w_any;
    logic          w_we;
    logic [3:0]    w_be;
    logic [AW-3:0] w_idx;
    logic [31:0]   w_wdata;
    logic          w_inr;
    logic [31:0]   w_rdata;
    logic [3:0]    w_wait_nxt;

    // Port 1 only overrides the core once it has been refused MAX_WAIT cycles in a row.
    always_comb begin
        w_sel1 = m1_req && (!m0_req || (r_wait_cnt == LP_MAX));
        w_sel0 = m0_req && !w_sel1;
        w_any  = w_sel0 || w_sel1;
    end

    always_comb begin
        w_we    = w_sel1 ? m1_we    : m0_we;
        w_be    = w_sel1 ? m1_be    : m0_be;
        w_idx   = w_sel1 ? m1_addr[AW-1:2] : m0_addr[AW-1:2];
        w_wdata = w_sel1 ? m1_wdata : m0_wdata;
        w_inr   = (w_idx < LP_DEPTH);
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!m1_req || w_sel1) begin
            w_wait_nxt = 4'd0;
        end else if (r_wait_cnt < LP_MAX) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end
    end

    // Everything visible is masked while reset is held, including a response already in flight.
    always_comb begin
        m0_gnt    = rst_n && w_sel0;
        m1_gnt    = rst_n && w_sel1;
        ram_en    = rst_n && w_any && w_inr;
        ram_we    = ram_en && w_we;
        ram_be    = ram_we ? w_be : 4'd0;
        ram_addr  = ram_en ? w_idx[IW-1:0] : '0;
        ram_wdata = ram_we ? w_wdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt   <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_sel   <= 1'b0;
            r_resp_we    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_wait_cnt   <= w_wait_nxt;
            r_resp_valid <= w_any;
            r_resp_sel   <= w_sel1;
            r_resp_we    <= w_we;
            r_resp_err   <= w_any && !w_inr;
        end
    end

    always_comb begin
        w_rdata   = (r_resp_valid && !r_resp_we && !r_resp_err) ? ram_rdata : 32'd0;
        m0_rvalid = rst_n && r_resp_valid && !r_resp_sel;
        m1_rvalid = rst_n && r_resp_valid && r_resp_sel;
        m0_rdata  = m0_rvalid ? w_rdata : 32'd0;
        m1_rdata  = m1_rvalid ? w_rdata : 32'd0;
        m0_err    = m0_rvalid && r_resp_err;
        m1_err    = m1_rvalid && r_resp_err;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: RAM model, reference arbiter/memory model and response scoreboard.
module tb_dmem_arbiter;

    localparam int DEPTH    = 8;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [3:0]  ram_be;
    logic [2:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;

    dmem_arbiter #(.AW(32), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem  [DEPTH];
    logic [31:0] gold [DEPTH];
    int          nchk = 0;
    int          nerr = 0;
    int          cyc  = 0;
    int          tb_wait = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            gold[i] = 32'h1000_0000 + 32'(i);
        end
        gold[1] = 32'hDEAD_BEEF;
        gold[2] = 32'h1122_3344;
        for (int i = 0; i < DEPTH; i++) mem[i] = gold[i];
    end

    // Synchronous RAM: read data one cycle after the access.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit          w0, w1, we, inr;
        logic [3:0]  be;
        logic [31:0] ad, wd;
        int          idx;
        exp_t        e;
        if (!rst_n) begin
            chk("rst_ctrl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_en, ram_we}), 32'd0);
            chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
            chk("rst_ram", ram_wdata | 32'({ram_be, ram_addr}), 32'd0);
            q.delete();
            tb_wait = 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.port) begin
                    chk("m1_rvalid", 32'(m1_rvalid), 32'd1);
                    chk("m1_rdata", m1_rdata, e.data);
                    chk("m1_err", 32'(m1_err), 32'(e.err));
                    chk("m0_quiet", 32'(m0_rvalid) | m0_rdata, 32'd0);
                end else begin
                    chk("m0_rvalid", 32'(m0_rvalid), 32'd1);
                    chk("m0_rdata", m0_rdata, e.data);
                    chk("m0_err", 32'(m0_err), 32'(e.err));
                    chk("m1_quiet", 32'(m1_rvalid) | m1_rdata, 32'd0);
                end
            end else begin
                chk("no_rvalid", 32'({m0_rvalid, m1_rvalid, m0_err, m1_err}), 32'd0);
                chk("no_rdata", m0_rdata | m1_rdata, 32'd0);
            end

            w1 = m1_req && (!m0_req || tb_wait == MAX_WAIT);
            w0 = m0_req && !w1;
            chk("m0_gnt", 32'(m0_gnt), 32'(w0));
            chk("m1_gnt", 32'(m1_gnt), 32'(w1));
            if (w0 || w1) begin
                we = w1 ? m1_we : m0_we;
                be = w1 ? m1_be : m0_be;
                ad = w1 ? m1_addr : m0_addr;
                wd = w1 ? m1_wdata : m0_wdata;
                idx = int'(ad >> 2);
                inr = (idx < DEPTH);
                e.due  = cyc + 1;
                e.port = w1;
                e.err  = !inr;
                e.data = 32'd0;
                if (inr) begin
                    chk("ram_en", 32'(ram_en), 32'd1);
                    chk("ram_we", 32'(ram_we), 32'(we));
                    chk("ram_addr", 32'(ram_addr), 32'(idx));
                    if (we) begin
                        chk("ram_be", 32'(ram_be), 32'(be));
                        chk("ram_wdata", ram_wdata, wd);
                        for (int b = 0; b < 4; b++)
                            if (be[b]) gold[idx][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        e.data = gold[idx];
                    end
                end else begin
                    chk("ram_en_oor", 32'(ram_en), 32'd0);
                end
                q.push_back(e);
            end else begin
                chk("ram_idle", 32'({ram_en, ram_we}), 32'd0);
            end
            tb_wait = (!m1_req || w1) ? 0 : ((tb_wait < MAX_WAIT) ? tb_wait + 1 : tb_wait);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit p, input bit rq, input bit we, input logic [3:0] be,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (p) begin
            m1_req = rq; m1_we = we; m1_be = be; m1_addr = ad; m1_wdata = wd;
        end else begin
            m0_req = rq; m0_we = we; m0_be = be; m0_addr = ad; m0_wdata = wd;
        end
    endtask

    int g1_seen;
    int g1_gap;

    initial begin
        bit p0, p1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // single load from the core
        set_m(0, 1, 0, 4'h0, 32'h4, 32'h0); step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0); step();

        // byte store then load of the same word on consecutive cycles
        set_m(0, 1, 1, 4'b0010, 32'h8, 32'h0000_AB00); step();
        set_m(0, 1, 0, 4'h0, 32'h8, 32'h0); step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0); step();

        // out-of-range load from port 1
        set_m(1, 1, 0, 4'h0, 32'h20, 32'h0); step();
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0); step();

        // alternating single-port requests
        set_m(0, 1, 0, 4'h0, 32'hC, 32'h0); step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1, 0, 4'h0, 32'h10, 32'h0); step();
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0); step();

        // full-word store from port 1, then read back by the core
        set_m(1, 1, 1, 4'hF, 32'h18, 32'hCAFE_F00D); step();
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(0, 1, 0, 4'h0, 32'h18, 32'h0); step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0); step();

        // continuous contention: port 1 must win exactly every fifth cycle
        set_m(0, 1, 0, 4'h0, 32'h4, 32'h0);
        set_m(1, 1, 0, 4'h0, 32'h1C, 32'h0);
        g1_seen = 0;
        g1_gap = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m1_gnt) begin
                chk("starve_gap", 32'(g1_gap), 32'(MAX_WAIT));
                g1_seen++;
                g1_gap = 0;
            end else begin
                g1_gap++;
            end
            step();
        end
        chk("starve_wins", 32'(g1_seen), 32'd2);
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        set_m(1, 0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // reset while a granted load is in flight: its response is dropped
        set_m(0, 1, 0, 4'h0, 32'h4, 32'h0); step();
        set_m(0, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        // random traffic with req held until granted, some addresses out of range
        p0 = 0;
        p1 = 0;
        for (int i = 0; i < 80; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1;
                set_m(0, 1, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 9)) << 2, $urandom);
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1;
                set_m(1, 1, 1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 9)) << 2, $urandom);
            end
            @(negedge clk);
            if (m0_gnt) p0 = 0;
            if (m1_gnt) p1 = 0;
            step();
            if (!p0) m0_req = 1'b0;
            if (!p1) m1_req = 1'b0;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) step();
        chk("q_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, checks=%0d", nchk);
        $fatal(1);
    end

endmodule
